// File: rtl/keypad_event_queue.sv
// Keypad debounce plus event FIFO: one queued keycode per qualified press,
// drained by a valid/ready consumer.
module keypad_event_queue #(
  parameter int STABLE_CYCLES  = 4,
  parameter int RELEASE_CYCLES = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    raw_code,
  output logic [3:0]                    key_code,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0]    STABLE_N  = 8'(STABLE_CYCLES);
  localparam logic [7:0]    RELEASE_N = 8'(RELEASE_CYCLES);
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHECK,
    HELD,
    RELEASE_CHECK
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d;
  logic          present;
  logic          push;

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, pop, push_ok;

  assign present = (raw_code <= 4'd11);
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (present) begin
          cand_d  = raw_code;
          cnt_d   = 8'd1;
          state_d = PRESS_CHECK;
        end
      end
      PRESS_CHECK: begin
        if (!present) begin
          state_d = IDLE;
        end else if (raw_code == cand_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == STABLE_N) begin
            push    = 1'b1;
            state_d = HELD;
          end
        end else begin
          cand_d = raw_code;
          cnt_d  = 8'd1;
        end
      end
      HELD: begin
        if (!present) begin
          cnt_d   = 8'd1;
          state_d = RELEASE_CHECK;
        end
      end
      RELEASE_CHECK: begin
        if (present) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == RELEASE_N) state_d = IDLE;
        end
      end
    endcase
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign pop     = !empty && key_ready;
  // A full queue still takes a press when the head leaves on the same edge.
  assign push_ok = push && (!full || pop);

  always_comb begin
    wr_d    = push_ok ? wr_q + PTR_ONE : wr_q;
    rd_d    = pop ? rd_q + PTR_ONE : rd_q;
    ovf_d   = ovf_q | (push && full && !pop);
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RELEASE_CHECK;
      cnt_q   <= '0;
      cand_q  <= 4'hF;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= cand_q;
  end

  assign key_valid  = !empty;
  assign key_code   = empty ? 4'hF : mem_q[rd_q];
  assign overflow   = ovf_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Directed bench for keypad_event_queue: a scoreboard queue holds the
// keycodes expected at the head and is checked before every clock edge.
module tb_keypad_event_queue;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [3:0] raw_code;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overflow;
  logic [2:0] fifo_count;

  int tests;
  int fails;
  logic [3:0] sb[$];
  logic exp_ovf;

  keypad_event_queue #(
    .STABLE_CYCLES (4),
    .RELEASE_CYCLES(4),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_code  (raw_code),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overflow  (overflow),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    logic [3:0] exp_code;
    exp_code = (sb.size() == 0) ? 4'hF : sb[0];
    chk({tag, " valid"}, 8'(key_valid), 8'(sb.size() != 0));
    chk({tag, " code"}, 8'(key_code), 8'(exp_code));
    chk({tag, " count"}, 8'(fifo_count), 8'(sb.size()));
    chk({tag, " ovf"}, 8'(overflow), 8'(exp_ovf));
  endtask

  // One sample: acc marks the edge on which a press must be accepted.
  task automatic step(input logic [3:0] code, input logic rdy,
                      input logic acc, input string tag);
    logic popping;
    raw_code  = code;
    key_ready = rdy;
    chk_outputs(tag);
    popping = rdy && (sb.size() != 0);
    if (acc && sb.size() == DEPTH && !popping) exp_ovf = 1'b1;
    else if (acc) sb.push_back(code);
    if (popping) void'(sb.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code, input logic rdy_on_acc);
    repeat (3) step(code, 1'b0, 1'b0, "press");
    step(code, rdy_on_acc, 1'b1, "accept");
  endtask

  task automatic release_key();
    repeat (4) step(4'hF, 1'b0, 1'b0, "release");
  endtask

  task automatic drain(input int n);
    repeat (n) step(4'hF, 1'b1, 1'b0, "pop");
    step(4'hF, 1'b0, 1'b0, "drained");
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    exp_ovf   = 1'b0;
    rst       = 1'b1;
    raw_code  = 4'hF;
    key_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset");
    rst = 1'b0;

    // Clean press after reset, held past acceptance.
    release_key();
    press(4'd7, 1'b0);
    repeat (2) step(4'd7, 1'b0, 1'b0, "hold7");
    release_key();
    drain(1);

    // Bounce restarts the check; a code change restarts the count.
    step(4'd3, 1'b0, 1'b0, "b3");
    step(4'd3, 1'b0, 1'b0, "b3");
    step(4'hF, 1'b0, 1'b0, "bgap");
    press(4'd3, 1'b0);
    release_key();
    drain(1);
    step(4'd3, 1'b0, 1'b0, "c3");
    step(4'd3, 1'b0, 1'b0, "c3");
    press(4'd5, 1'b0);
    release_key();
    drain(1);

    // Release glitch, then a second press popping a one-entry queue.
    press(4'd9, 1'b0);
    step(4'hF, 1'b0, 1'b0, "g");
    step(4'hF, 1'b0, 1'b0, "g");
    step(4'd9, 1'b0, 1'b0, "g9");
    release_key();
    press(4'd9, 1'b1);
    release_key();
    drain(1);

    // Full queue with simultaneous push and pop.
    for (int i = 1; i <= 4; i++) begin
      press(4'(i), 1'b0);
      release_key();
    end
    press(4'd6, 1'b1);
    release_key();
    drain(4);

    // Overflow: fifth press dropped, flag sticky.
    for (int i = 1; i <= 5; i++) begin
      press(4'(i), 1'b0);
      release_key();
    end
    drain(4);

    // Reset mid-press with two events queued.
    press(4'd1, 1'b0);
    release_key();
    press(4'd2, 1'b0);
    release_key();
    step(4'd8, 1'b0, 1'b0, "pre8");
    step(4'd8, 1'b0, 1'b0, "pre8");
    #3;
    rst = 1'b1;
    #1;
    sb.delete();
    exp_ovf = 1'b0;
    chk_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) step(4'd8, 1'b0, 1'b0, "held8");
    release_key();
    press(4'd8, 1'b0);
    release_key();
    drain(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_event_queue.md
# keypad_event_queue

Debounces raw keycodes from the keypad scan stage and turns each qualified key press into exactly one queued event for the safe control FSM. It sits between the membrane scanner's 4-bit data output and the code-checking logic, and buffers up to FIFO_DEPTH presses behind a valid/ready handshake so that no digit is lost while the consumer is busy.

## Interface
- STABLE_CYCLES, default 4: consecutive identical samples needed to accept a press; legal range 2..255.
- RELEASE_CYCLES, default 4: consecutive no-key samples needed to re-arm after a press; legal range 2..255.
- FIFO_DEPTH, default 4: event queue depth; power of two, at least 2.
- clk  in  1  single block clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- raw_code  in  4  scanner keycode, synchronous to clk. Codes 0–9 are digits, 10 is `*`, 11 is `#`. Codes 12–15 mean no key; 15 is the scanner idle code.
- key_code  out  4  head-of-queue keycode; reads 4'hF when the queue is empty.
- key_valid  out  1  high while the queue is non-empty.
- key_ready  in  1  consumer accepts the head entry on a clock edge where key_valid && key_ready.
- overflow  out  1  sticky flag; set when a qualified press is dropped because the queue is full; cleared only by rst.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued events, 0..FIFO_DEPTH.

## Operation
- present = (raw_code <= 11). There is no input synchroniser; raw_code is sampled every clk edge.
- Debounce FSM states: IDLE, PRESS_CHECK, HELD, RELEASE_CHECK. It uses an 8-bit counter cnt and a 4-bit candidate register.
- IDLE:
  - present → candidate <= raw_code, cnt <= 1, go to PRESS_CHECK.
  - otherwise stay.
- PRESS_CHECK:
  - raw_code == candidate → cnt++. When the incremented value equals STABLE_CYCLES, push candidate into the queue and go to HELD.
  - present but a different code → candidate <= raw_code, cnt <= 1, stay.
  - not present → IDLE; nothing is pushed.
- HELD:
  - present (any code) → stay. Code changes while held never generate events.
  - not present → cnt <= 1, go to RELEASE_CHECK.
- RELEASE_CHECK:
  - not present → cnt++. When it reaches RELEASE_CYCLES, go to IDLE.
  - present → HELD. This is treated as bounce; no event is generated.
- Queue: circular buffer with read/write pointers and a count.
  - push = FSM acceptance; pop = key_valid && key_ready.
  - Push while full and no pop: the entry is dropped, overflow <= 1, and the queue is unchanged.
  - Push while full with a simultaneous pop: both happen; count stays FIFO_DEPTH and overflow is not set.
  - Push and pop on a queue holding one entry: the new entry becomes head; count stays 1.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset values:
  - FSM = RELEASE_CHECK with cnt = 0.
  - Queue is empty: key_valid 0, key_code 4'hF, fifo_count 0.
  - overflow 0.
- Because the FSM resets into RELEASE_CHECK, a key held through reset (or asserted mid-operation reset) produces no event. raw_code must read no-key for RELEASE_CYCLES samples before the first press can be accepted. Reset asserted mid-press discards the press and all queued events.

## Timing
- Press latency:
  - Let the first edge sampling a new code be edge E.
  - The press is accepted at edge E+STABLE_CYCLES-1.
  - key_valid / key_code reflect it in the cycle after that edge (registered outputs).
  - With defaults and an empty queue: code first sampled at edge 0 → key_valid high after edge 3.
- Re-arm: after release is first sampled at edge R, IDLE is entered at edge R+RELEASE_CYCLES-1. The next press can be sampled from edge R+RELEASE_CYCLES.
- Minimum spacing between events at the input is STABLE_CYCLES + RELEASE_CYCLES samples.
- Handshake:
  - Head data is stable while key_valid is high and key_ready is low.
  - After a pop, the next entry (or 4'hF / key_valid 0) is visible in the following cycle.
  - key_ready is ignored while key_valid is low.
- fifo_count and overflow are registered; they update on the same edge as the push or pop.

## Test plan
- Reset then clean press: hold raw_code=15 for 4 cycles, then 7 for 6 cycles, then 15 → exactly one event with key_code 7, key_valid rising after the 4th sample of 7, and fifo_count=1.
- Bounce: drive 3,3,15,3,3,3,3 then release → one event (3), accepted on the 4th consecutive 3. A code change 3→5 mid-check restarts the count, so 5 needs 4 stable samples.
- Release glitch: press 9 (accepted), then 15,15,9,15×4 → still one event. A second 9 after a full release yields a second event.
- Overflow: key_ready=0, enter 1,2,3,4,5 cleanly → fifo_count=4, overflow=1. Then pop 4 times with key_ready=1 → outputs 1,2,3,4, then key_valid=0 and key_code=4'hF. overflow stays 1 until rst.
- Full with simultaneous push and pop: queue holds 4 entries, key_ready held high on the acceptance edge of 6 → count remains 4, overflow stays 0, and 6 appears last in order.
- Reset mid-operation: with 2 events queued and key 8 held, assert rst asynchronously → outputs go to reset values immediately. After release with 8 still held, no event occurs. Event 8 appears only after ≥4 no-key samples and a new press.
